// File: rtl/ntt_sched.sv
// Layer scheduler for an in-place NTT engine: launches the address generator once per
// butterfly layer, waits out the butterfly pipeline, and ping-pongs the coefficient banks.
module ntt_sched #(
    parameter int NUM_LAYERS = 8,
    parameter int BF_LAT     = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  logic       agu_done_i,
    output logic       agu_start_o,
    output logic [2:0] layer_o,
    output logic       bank_sel_o,
    output logic [7:0] twiddle_base_o,
    output logic       mode_o,
    output logic       wb_en_o,
    output logic       busy_o,
    output logic       done_o
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [2:0] LAST_LAYER = 3'(NUM_LAYERS - 1);
    localparam logic [3:0] DRAIN_INIT = 4'(BF_LAT - 1);

    state_t     state;
    logic [3:0] drain_cnt;

    // Inverse transforms walk the twiddle table from the widest stride down.
    function automatic logic [7:0] twiddle_for(input logic [2:0] layer, input logic mode);
        logic [2:0] l;
        l = mode ? (LAST_LAYER - layer) : layer;
        return 8'd1 << l;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            layer_o        <= 3'd0;
            bank_sel_o     <= 1'b0;
            mode_o         <= 1'b0;
            drain_cnt      <= 4'd0;
            twiddle_base_o <= 8'd1;
            agu_start_o    <= 1'b0;
            wb_en_o        <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
        end else begin
            agu_start_o <= 1'b0;
            done_o      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mode_o         <= mode_i;
                        layer_o        <= 3'd0;
                        bank_sel_o     <= 1'b0;
                        twiddle_base_o <= twiddle_for(3'd0, mode_i);
                        agu_start_o    <= 1'b1;
                        busy_o         <= 1'b1;
                        state          <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    wb_en_o <= 1'b1;
                    state   <= RUN;
                end
                RUN: begin
                    if (agu_done_i) begin
                        drain_cnt <= DRAIN_INIT;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last butterfly results leave the pipeline on the cycle the counter reads zero.
                    if (drain_cnt == 4'd0) begin
                        wb_en_o <= 1'b0;
                        if (layer_o == LAST_LAYER) begin
                            done_o <= 1'b1;
                            state  <= FINISH;
                        end else begin
                            layer_o        <= layer_o + 3'd1;
                            bank_sel_o     <= ~bank_sel_o;
                            twiddle_base_o <= twiddle_for(layer_o + 3'd1, mode_o);
                            agu_start_o    <= 1'b1;
                            state          <= LAUNCH;
                        end
                    end else begin
                        drain_cnt <= drain_cnt - 4'd1;
                    end
                end
                FINISH: begin
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_o  <= 1'b0;
                    wb_en_o <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_sched.sv
// Self-checking bench for ntt_sched: table-driven full transforms with a per-layer
// scoreboard, plus hand-written sequences for restart, abort and back-to-back corners.
module tb_ntt_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, mode_in, agu_done, resp_done, spur_done;
    logic       agu_start, bank_sel, mode_out, wb_en, busy, done;
    logic [2:0] layer;
    logic [7:0] twiddle;

    logic       start_fast;
    logic       agu_start_fast, bank_sel_fast, mode_fast, wb_en_fast, busy_fast, done_fast;
    logic [2:0] layer_fast;
    logic [7:0] twiddle_fast;

    assign agu_done = resp_done | spur_done;

    ntt_sched dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode_in), .agu_done_i(agu_done),
        .agu_start_o(agu_start), .layer_o(layer), .bank_sel_o(bank_sel),
        .twiddle_base_o(twiddle), .mode_o(mode_out), .wb_en_o(wb_en),
        .busy_o(busy), .done_o(done)
    );

    ntt_sched #(.NUM_LAYERS(4), .BF_LAT(1)) dut_fast (
        .clk_i(clk), .rst_i(rst), .start_i(start_fast), .mode_i(1'b0), .agu_done_i(1'b1),
        .agu_start_o(agu_start_fast), .layer_o(layer_fast), .bank_sel_o(bank_sel_fast),
        .twiddle_base_o(twiddle_fast), .mode_o(mode_fast), .wb_en_o(wb_en_fast),
        .busy_o(busy_fast), .done_o(done_fast)
    );

    typedef struct {
        logic [2:0] layer;
        logic       bank;
        logic [7:0] twiddle;
        logic       mode;
    } sb_item_t;

    typedef struct {
        logic       mode;
        int         delay;
        int         exp_busy;
        int         exp_wb;
        logic [7:0] exp_twiddle;
    } vec_t;

    sb_item_t sb_q[$];
    sb_item_t sb_item;
    bit       sb_en = 1'b0;
    int       resp_delay = 4;
    int       checks = 0;
    int       failures = 0;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Address-generator model: answers each launch resp_delay cycles later.
    initial begin
        resp_done = 1'b0;
        forever begin
            @(negedge clk);
            if (agu_start) begin
                repeat (resp_delay) @(negedge clk);
                resp_done = 1'b1;
                @(negedge clk);
                resp_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (sb_en && agu_start) begin
            if (sb_q.size() == 0) begin
                check_output("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_item = sb_q.pop_front();
                check_output("sb_layer", 32'(layer), 32'(sb_item.layer));
                check_output("sb_bank_sel", 32'(bank_sel), 32'(sb_item.bank));
                check_output("sb_twiddle", 32'(twiddle), 32'(sb_item.twiddle));
                check_output("sb_mode", 32'(mode_out), 32'(sb_item.mode));
                check_output("sb_wb_en_at_launch", 32'(wb_en), 32'd0);
                check_output("sb_busy_at_launch", 32'(busy), 32'd1);
            end
        end
    end

    task automatic push_expected(input logic m);
        sb_item_t it;
        for (int l = 0; l < 8; l++) begin
            it.layer   = 3'(l);
            it.bank    = l[0];
            it.twiddle = 8'(1 << (m ? (7 - l) : l));
            it.mode    = m;
            sb_q.push_back(it);
        end
    endtask

    task automatic apply_stimulus(input logic m, input int delay,
                                  output int busy_cnt, output int wb_cnt, output int done_cnt);
        bit seen;
        resp_delay = delay;
        push_expected(m);
        start   = 1'b1;
        mode_in = m;
        busy_cnt = 0; wb_cnt = 0; done_cnt = 0; seen = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (k == 0) begin
                start   = 1'b0;
                mode_in = ~m;
            end
            if (busy) busy_cnt++;
            if (wb_en) wb_cnt++;
            if (done) done_cnt++;
            if (busy) seen = 1'b1;
            else if (seen) break;
        end
        check_output("transform_end_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        vec_t vecs[4];
        int   busy_cnt, wb_cnt, done_cnt, cnt, pulses;
        bit   found;

        vecs[0] = '{1'b0, 128, 1065, 1056, 8'd128};
        vecs[1] = '{1'b1, 128, 1065, 1056, 8'd1};
        vecs[2] = '{1'b0, 1, 49, 40, 8'd128};
        vecs[3] = '{1'b1, 5, 81, 72, 8'd1};

        rst = 1'b1; start = 1'b0; mode_in = 1'b1; spur_done = 1'b0; start_fast = 1'b0;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_agu_start", 32'(agu_start), 32'd0);
        check_output("rst_wb_en", 32'(wb_en), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_twiddle", 32'(twiddle), 32'd1);
        check_output("rst_layer", 32'(layer), 32'd0);
        check_output("rst_bank_sel", 32'(bank_sel), 32'd0);
        check_output("rst_mode", 32'(mode_out), 32'd0);
        check_output("rst_fast_twiddle", 32'(twiddle_fast), 32'd1);
        check_output("rst_fast_busy", 32'(busy_fast), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_busy", 32'(busy), 32'd0);
        check_output("post_rst_twiddle", 32'(twiddle), 32'd1);

        sb_en = 1'b1;
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].mode, vecs[i].delay, busy_cnt, wb_cnt, done_cnt);
            check_output($sformatf("vec%0d_busy_cycles", i), 32'(busy_cnt), 32'(vecs[i].exp_busy));
            check_output($sformatf("vec%0d_wb_cycles", i), 32'(wb_cnt), 32'(vecs[i].exp_wb));
            check_output($sformatf("vec%0d_done_pulses", i), 32'(done_cnt), 32'd1);
            check_output($sformatf("vec%0d_sb_left", i), 32'(sb_q.size()), 32'd0);
            check_output($sformatf("vec%0d_hold_layer", i), 32'(layer), 32'd7);
            check_output($sformatf("vec%0d_hold_bank", i), 32'(bank_sel), 32'd1);
            check_output($sformatf("vec%0d_hold_mode", i), 32'(mode_out), 32'(vecs[i].mode));
            check_output($sformatf("vec%0d_hold_twiddle", i), 32'(twiddle), 32'(vecs[i].exp_twiddle));
            sb_q.delete();
            repeat (2) @(negedge clk);
        end

        // start with flipped mode during RUN of layer 3 must be ignored
        fork
            apply_stimulus(1'b0, 20, busy_cnt, wb_cnt, done_cnt);
            begin
                for (int k = 0; k < 2000; k++) begin
                    @(negedge clk);
                    if (agu_start && layer == 3'd3) break;
                end
                repeat (5) @(negedge clk);
                start = 1'b1; mode_in = 1'b1;
                @(negedge clk);
                start = 1'b0; mode_in = 1'b0;
            end
        join
        check_output("restart_busy_cycles", 32'(busy_cnt), 32'd201);
        check_output("restart_done_pulses", 32'(done_cnt), 32'd1);
        check_output("restart_mode", 32'(mode_out), 32'd0);
        check_output("restart_sb_left", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);

        // abort with reset in DRAIN of layer 5
        resp_delay = 10;
        push_expected(1'b1);
        start = 1'b1; mode_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (agu_start && layer == 3'd5) begin
                found = 1'b1;
                break;
            end
        end
        check_output("abort_reached_layer5", 32'(found), 32'd1);
        repeat (11) @(negedge clk);
        check_output("abort_in_drain_wb_en", 32'(wb_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("abort_busy", 32'(busy), 32'd0);
        check_output("abort_layer", 32'(layer), 32'd0);
        check_output("abort_bank_sel", 32'(bank_sel), 32'd0);
        check_output("abort_mode", 32'(mode_out), 32'd0);
        check_output("abort_twiddle", 32'(twiddle), 32'd1);
        check_output("abort_wb_en", 32'(wb_en), 32'd0);
        cnt = 0; pulses = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) cnt++;
            if (busy) pulses++;
        end
        check_output("abort_no_done", 32'(cnt), 32'd0);
        check_output("abort_stays_idle", 32'(pulses), 32'd0);
        sb_q.delete();

        // spurious agu_done in IDLE
        spur_done = 1'b1;
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy || agu_start) cnt++;
        end
        spur_done = 1'b0;
        check_output("spurious_idle_activity", 32'(cnt), 32'd0);

        // BF_LAT=1, 4 layers, agu_done tied high, start held for two transforms
        start_fast = 1'b1;
        cnt = 0; pulses = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (agu_start_fast) pulses++;
            if (done_fast) begin
                cnt = k;
                break;
            end
        end
        check_output("fast_done_latency", 32'(cnt), 32'd13);
        check_output("fast_launches", 32'(pulses), 32'd4);
        check_output("fast_layer", 32'(layer_fast), 32'd3);
        check_output("fast_bank_sel", 32'(bank_sel_fast), 32'd1);
        check_output("fast_twiddle", 32'(twiddle_fast), 32'd8);
        check_output("fast_mode", 32'(mode_fast), 32'd0);
        cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (k == 1) check_output("fast_idle_gap_busy", 32'(busy_fast), 32'd0);
            if (done_fast) begin
                cnt = k;
                break;
            end
        end
        start_fast = 1'b0;
        check_output("fast_back_to_back_gap", 32'(cnt), 32'd14);
        repeat (3) @(negedge clk);
        check_output("fast_final_idle", 32'(busy_fast), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/ntt_sched.md
NTT_SCHED -- requirements
Module: ntt_sched

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 8: number of butterfly layers per transform (1..8).
REQ-002 SHALL have parameter BF_LAT, default 4: butterfly pipeline latency in cycles (1..15).
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk_i, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port start_i, input, 1 bit: transform request, sampled only in IDLE.
REQ-007 SHALL have port mode_i, input, 1 bit: 0 = forward NTT, 1 = inverse NTT; captured with start_i.
REQ-008 SHALL have port agu_done_i, input, 1 bit: address generator finished the current layer.
REQ-009 SHALL have port agu_start_o, output, 1 bit: one-cycle pulse launching the address generator for one layer.
REQ-010 SHALL have port layer_o, output, 3 bits: current layer counter, 0..NUM_LAYERS-1.
REQ-011 SHALL have port bank_sel_o, output, 1 bit: read bank select; the write bank is ~bank_sel_o.
REQ-012 SHALL have port twiddle_base_o, output, 8 bits: first twiddle index of the current layer.
REQ-013 SHALL have port mode_o, output, 1 bit: captured mode, stable for the whole transform.
REQ-014 SHALL have port wb_en_o, output, 1 bit: write-back enable for the coefficient memory.
REQ-015 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.
REQ-016 SHALL have port done_o, output, 1 bit: one-cycle completion pulse.

Function
REQ-017 SHALL implement FSM states IDLE, LAUNCH, RUN, DRAIN and FINISH, all outputs registered or decoded from registered state.
REQ-018 IDLE: on start_i=1, SHALL capture mode_i into mode_o, clear layer_o to 0 and bank_sel_o to 0, then go to LAUNCH.
REQ-019 LAUNCH: SHALL assert agu_start_o for exactly this one cycle, then go to RUN.
REQ-020 RUN: SHALL wait for agu_done_i=1; on it, SHALL load the drain counter with BF_LAT-1 and go to DRAIN.
REQ-021 DRAIN: SHALL last exactly BF_LAT cycles, decrementing the counter each cycle and leaving when it reads 0.
REQ-022 On DRAIN exit with layer_o = NUM_LAYERS-1, SHALL go to FINISH.
REQ-023 On any other DRAIN exit, SHALL increment layer_o, toggle bank_sel_o and go to LAUNCH.
REQ-024 FINISH: SHALL assert done_o for exactly one cycle, then go to IDLE; layer_o, bank_sel_o and mode_o hold their values until the next start.
REQ-025 wb_en_o SHALL be 1 in RUN and DRAIN and 0 in all other states.
REQ-026 twiddle_base_o SHALL be 1<<L, with L = layer_o for the forward NTT and L = NUM_LAYERS-1-layer_o for the inverse NTT; the result is 8 bits, no overflow for L<=7.
REQ-027 start_i outside IDLE SHALL be ignored, with no re-capture of mode and no restart.
REQ-028 agu_done_i outside RUN SHALL be ignored.
REQ-029 agu_done_i high in the same cycle the FSM enters RUN SHALL not count; it is only sampled while in RUN.
REQ-030 start_i held high continuously SHALL start a new transform on the first IDLE cycle after FINISH, i.e. a one-cycle IDLE gap.

Reset
REQ-031 rst_i=1 SHALL force IDLE and clear layer_o, bank_sel_o, mode_o and the drain counter to 0 on the next edge.
REQ-032 During and immediately after rst_i=1, agu_start_o, wb_en_o, busy_o and done_o SHALL all be 0, and twiddle_base_o SHALL be 1.
REQ-033 rst_i SHALL take priority over all other inputs in any state, including mid-transform; no done_o pulse is produced for an aborted transform.

Verification
REQ-034 Forward NTT, defaults, agu_done_i returned 128 cycles after each agu_start_o -> 8 agu_start_o pulses; twiddle_base_o = 1,2,4,...,128; bank_sel_o = 0,1,0,...,1; one done_o pulse; busy_o high for 8*(1+128+4)+1 cycles.
REQ-035 Inverse NTT, same stimulus -> twiddle_base_o = 128,64,...,1 across layers 0..7; mode_o = 1 throughout; one done_o pulse.
REQ-036 start_i pulsed during RUN of layer 3, with mode_i flipped -> no restart; mode_o unchanged; layer sequence continues 4..7.
REQ-037 rst_i asserted for one cycle in DRAIN of layer 5 -> next cycle IDLE, layer_o = 0, bank_sel_o = 0, busy_o = 0, and no done_o pulse.
REQ-038 BF_LAT=1 and agu_done_i tied high -> each layer takes LAUNCH 1 + RUN 1 + DRAIN 1 cycles; done_o arrives 3*NUM_LAYERS+1 cycles after start.
REQ-039 Spurious agu_done_i in IDLE, LAUNCH and DRAIN -> no state change other than the nominal sequence.
